// File: rtl/ai_vector_engine_pkg.sv
// ai_vec_pkg: opcodes, FSM states and the saturating adder shared by the vector engine
package ai_vec_pkg;
  localparam logic [2:0] OP_DOT = 3'b000, OP_MAC = 3'b001, OP_RELU = 3'b010;
  localparam logic [2:0] OP_STEP = 3'b011, OP_CLRACC = 3'b100, OP_EMUL = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;
  localparam int SAT_W = 256;
  function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a, input logic signed [SAT_W-1:0] b, input int w);
    logic signed [SAT_W-1:0] s, mx;
    s = a + b;
    mx = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    return s > mx ? mx : s < ~mx ? ~mx : s;
  endfunction
endpackage

// File: rtl/ai_mac_chunk.sv
// ai_mac_chunk: signed sum of MAC_PER_CYCLE lane products starting at lane idx
module ai_mac_chunk
  import ai_vec_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ELEM_W = 32,
  parameter int MAC_PER_CYCLE = 1,
  parameter int ACC_W = 64,
  parameter int IW = 2
) (
  input  logic [LANES*ELEM_W-1:0] vec_a,
  input  logic [LANES*ELEM_W-1:0] vec_b,
  input  logic [IW-1:0]           idx,
  output logic [ACC_W-1:0]        sum
);
  logic signed [2*ELEM_W-1:0] p;
  always_comb begin
    sum = '0;
    p = '0;
    for (int k = 0; k < MAC_PER_CYCLE; k++) begin
      p = (2*ELEM_W)'($signed(vec_a[(int'(idx) + k) * ELEM_W +: ELEM_W])) * (2*ELEM_W)'($signed(vec_b[(int'(idx) + k) * ELEM_W +: ELEM_W]));
      sum = sum + ACC_W'(p);
    end
  end
endmodule

// File: rtl/ai_vector_engine.sv
// ai_vector_engine: multi-cycle dot/MAC/lane-op unit with valid/ready intake and result hold
module ai_vector_engine
  import ai_vec_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ELEM_W = 32,
  parameter int MAC_PER_CYCLE = 1,
  parameter int ACC_W = 64,
  parameter int SATURATE = 0,
  localparam int VEC_W = LANES * ELEM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       opcode,
  input  logic [VEC_W-1:0] vec_a,
  input  logic [VEC_W-1:0] vec_b,
  input  logic [4:0]       rd_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [VEC_W-1:0] result,
  output logic [4:0]       rd_out,
  output logic             err,
  output logic             busy,
  output logic             stall
);
  localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
  state_t state, state_n;
  logic [2:0] op_r;
  logic [VEC_W-1:0] a_r, b_r, lane_res;
  logic [ACC_W-1:0] acc_reg, psum, chunk, sum_n, acc_n;
  logic [IW-1:0] idx;
  logic [ELEM_W-1:0] ea, eb, pl;
  logic last, accept;
  ai_mac_chunk #(.LANES(LANES), .ELEM_W(ELEM_W), .MAC_PER_CYCLE(MAC_PER_CYCLE), .ACC_W(ACC_W), .IW(IW)) u_chunk (
    .vec_a(a_r), .vec_b(b_r), .idx(idx), .sum(chunk)
  );
  assign sum_n = psum + chunk;
  assign acc_n = SATURATE != 0 ? ACC_W'(sat_add(SAT_W'($signed(acc_reg)), SAT_W'($signed(sum_n)), ACC_W)) : acc_reg + sum_n;
  assign last = idx == IW'(LANES - MAC_PER_CYCLE);
  assign accept = start_valid && state == S_IDLE;
  assign start_ready = state == S_IDLE;
  assign busy = state != S_IDLE;
  assign result_valid = state == S_HOLD;
  assign stall = start_valid && !start_ready;
  // lane ops are evaluated on the live inputs so they register at the accept edge
  always_comb begin
    lane_res = '0;
    ea = '0;
    eb = '0;
    pl = '0;
    for (int i = 0; i < LANES; i++) begin
      ea = vec_a[i*ELEM_W +: ELEM_W];
      eb = vec_b[i*ELEM_W +: ELEM_W];
      pl = ea * eb;
      lane_res[i*ELEM_W +: ELEM_W] = opcode == OP_RELU ? (ea[ELEM_W-1] ? '0 : ea) :
                                     opcode == OP_STEP ? ELEM_W'(!ea[ELEM_W-1] && ea != '0) :
                                     opcode == OP_EMUL ? pl : '0;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = start_valid ? (opcode == OP_DOT || opcode == OP_MAC ? S_RUN : S_HOLD) : S_IDLE;
      S_RUN:   state_n = last ? S_HOLD : S_RUN;
      default: state_n = result_ready ? S_IDLE : S_HOLD;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      rd_out <= '0;
      result <= '0;
      err <= 1'b0;
      acc_reg <= '0;
      psum <= '0;
      idx <= '0;
    end else if (accept) begin
      op_r <= opcode;
      a_r <= vec_a;
      b_r <= vec_b;
      rd_out <= rd_in;
      result <= lane_res;
      err <= opcode[2] & opcode[1];
      psum <= '0;
      idx <= '0;
      if (opcode == OP_CLRACC) acc_reg <= '0;
    end else if (state == S_RUN) begin
      psum <= sum_n;
      idx <= idx + IW'(MAC_PER_CYCLE);
      if (last) result <= VEC_W'($signed(op_r == OP_MAC ? acc_n : sum_n));
      if (last && op_r == OP_MAC) acc_reg <= acc_n;
    end
endmodule

// File: doc/ai_vector_engine.md
Name: ai_vector_engine

Overview:
- Parametrised multi-cycle AI execution unit for the EX stage of the 128-bit pipeline.
- Supersedes the fixed-width dot/relu/step datapath and the separate start/busy/done controller.
- Lane count and element width are configurable. A persistent MAC accumulator with optional saturation is added.
- Operand intake and result delivery each use a valid/ready handshake. A stall output feeds the hazard logic.

Parameters:
- LANES, 4: number of vector elements per operand.
- ELEM_W, 32: element width in bits, signed two's complement.
- MAC_PER_CYCLE, 1: lanes reduced per RUN cycle. Must divide LANES.
- ACC_W, 64: accumulator width. Must satisfy ACC_W <= LANES*ELEM_W.
- SATURATE, 0: 0 = accumulator wraps modulo 2^ACC_W; 1 = signed saturation.
- VEC_W is a derived localparam, equal to LANES*ELEM_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. reset=0 clears all state immediately.
- start_valid  in  1  operation request.
- start_ready  out  1  engine can accept a request.
- opcode  in  3  operation select.
- vec_a  in  VEC_W  operand A; lane i is bits [i*ELEM_W +: ELEM_W].
- vec_b  in  VEC_W  operand B.
- rd_in  in  5  destination register tag.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- result  out  VEC_W  operation result.
- rd_out  out  5  tag of the result.
- err  out  1  result came from an illegal opcode.
- busy  out  1  state != IDLE.
- stall  out  1  start_valid && !start_ready.

Behaviour:
- Reset values: state=IDLE, result=0, rd_out=0, err=0, result_valid=0, accumulator acc_reg=0, lane index=0. After reset: busy=0, stall=0, start_ready=1.
- Opcodes:
  - 000 DOT: sum over lanes of a_i*b_i, computed in ACC_W bits, wraps; result = sign-extension to VEC_W.
  - 001 MAC: acc_reg <= acc_reg + dot(a,b); result = new acc_reg, sign-extended.
  - 010 RELU: per lane, max(a_i, 0).
  - 011 STEP: per lane, 1 if a_i > 0, else 0.
  - 100 CLRACC: acc_reg <= 0; result = 0.
  - 101 EMUL: per lane, low ELEM_W bits of signed a_i*b_i.
  - 110/111: result = 0, err = 1. acc_reg is unchanged.
- FSM states: IDLE, RUN, HOLD.
  - start_ready = 1 only in IDLE.
- IDLE:
  - Accept on start_valid. Latch vec_a, vec_b, opcode and rd_in at edge T.
  - DOT and MAC go to RUN with idx=0 and partial sum=0.
  - All other opcodes register the result at edge T and go to HOLD.
  - Lane ops are therefore visible one cycle after the start cycle.
- RUN:
  - Each edge adds MAC_PER_CYCLE products from lanes idx.. to the partial sum, then idx += MAC_PER_CYCLE.
  - On the edge that consumes the final chunk: register the result, update acc_reg for MAC, go to HOLD.
  - DOT/MAC latency is N = LANES/MAC_PER_CYCLE RUN cycles; result_valid rises after edge T+N.
- HOLD:
  - result_valid = 1. result, rd_out and err stay stable until result_ready = 1.
  - On the handshake, go to IDLE.
  - A start_valid in the same cycle as the handshake is not accepted. It is accepted in the following IDLE cycle.
- Saturation: when SATURATE=1, the MAC sum clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on signed overflow. DOT is never saturated.
- Products are full 2*ELEM_W signed, then sign-extended or truncated to ACC_W.
- reset=0 mid-RUN or mid-HOLD aborts the operation and clears acc_reg. No result is produced.
- start_valid while busy: stall=1 and the request is held upstream. Inputs are sampled only at acceptance.

Decomposition:
- Package ai_vec_pkg:
  - Opcode localparams: OP_DOT, OP_MAC, OP_RELU, OP_STEP, OP_CLRACC, OP_EMUL.
  - State encoding: S_IDLE, S_RUN, S_HOLD.
  - Saturating-add function, parametrised by width.
- Sub-module ai_mac_chunk: combinational signed sum of MAC_PER_CYCLE lane products. It is instantiated once and indexed by idx.

Test Plan:
- DOT, a={1,2,3,4}, b={5,6,7,8}, LANES=4, MAC_PER_CYCLE=1, result_ready=1 -> result=70 and result_valid exactly 4 edges after acceptance; busy high for those cycles.
- RELU a={-5,0,7,0x80000000} -> result lanes {0,0,7,0} one cycle after acceptance, err=0. STEP on the same input -> {0,0,1,0}.
- MAC {1,1,1,1}x{2,2,2,2} twice -> results 8 then 16. Then CLRACC -> 0. Then MAC once more -> 8.
- SATURATE=1, ACC_W=64, acc_reg preloaded via MACs to 2^63-8, then MAC giving +16 -> result 0x7FFF_FFFF_FFFF_FFFF. The same sequence with SATURATE=0 wraps to -2^63+8.
- Backpressure: result_ready held low for 3 cycles in HOLD while start_valid=1 -> result and rd_out stable, start_ready=0, stall=1. The second op is accepted the cycle after the handshake.
- reset pulsed low during the 2nd RUN cycle of a DOT -> outputs 0 and acc_reg=0 immediately. After release, a fresh DOT of {1,2,3,4}·{5,6,7,8} still returns 70. Illegal opcode 111 -> result 0, err=1.
